// File: rtl/result_collector_pkg.sv
// Shared types for the tile result collector: capture FSM states, tile record
// layout and default sizing constants.
package result_collector_pkg;

    localparam int unsigned TC_DATA_W = 32;
    localparam int unsigned TC_DEPTH  = 4;
    localparam int unsigned TC_CNT_W  = 32;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_GOT11,
        CAP_GOTEDGE
    } tile_cap_t;

    typedef struct packed {
        logic [TC_DATA_W-1:0] c11;
        logic [TC_DATA_W-1:0] c12;
        logic [TC_DATA_W-1:0] c21;
        logic [TC_DATA_W-1:0] c22;
        logic                 last;
    } tile_t;

    function automatic logic [1:0] push_count(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Element stream from the collector to the memory/bus writer (valid/ready).
interface result_collector_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/result_collector_tile_fifo.sv
// Synchronous FIFO of whole tiles; pointers carry a wrap bit so full/empty and
// level fall out of a pointer difference.
module tile_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A write into a full FIFO is fine when the head leaves in the same cycle.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/result_collector.sv
// Collects 2x2 PE accumulator tiles from the push11/pushedge/push22 pulse train,
// queues them and streams them out one element per valid/ready handshake.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned DATA_W = TC_DATA_W,
    parameter int unsigned DEPTH  = TC_DEPTH,
    parameter int unsigned CNT_W  = TC_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       tiles_total,
    input  logic                   push11,
    input  logic                   pushedge,
    input  logic                   push22,
    input  logic [DATA_W-1:0]      c11,
    input  logic [DATA_W-1:0]      c12,
    input  logic [DATA_W-1:0]      c21,
    input  logic [DATA_W-1:0]      c22,
    result_collector_if.master     out,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   seq_err,
    output logic                   all_done
);
    typedef struct packed {
        logic [DATA_W-1:0] c11;
        logic [DATA_W-1:0] c12;
        logic [DATA_W-1:0] c21;
        logic [DATA_W-1:0] c22;
        logic              last;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    tile_cap_t         state_q, state_d;
    logic [DATA_W-1:0] c11_q, c11_d;
    logic [DATA_W-1:0] c12_q, c12_d;
    logic [DATA_W-1:0] c21_q, c21_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [1:0]        idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic              seq_err_q, seq_err_d;
    logic              all_done_q, all_done_d;

    logic              commit;
    logic              seq_hit;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_tag;
    entry_t            wr_entry;
    entry_t            head;
    logic [ENTRY_W-1:0] rd_raw;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_en;
    logic              hs;
    logic              pop;
    logic [DATA_W-1:0] elem;

    // Capture FSM: assembles one tile from the three push pulses.
    always_comb begin
        state_d = state_q;
        c11_d   = c11_q;
        c12_d   = c12_q;
        c21_d   = c21_q;
        commit  = 1'b0;
        seq_hit = 1'b0;
        if (start) begin
            state_d = CAP_IDLE;
        end else if (push_count(push11, pushedge, push22) > 2'd1) begin
            seq_hit = 1'b1;
            state_d = CAP_IDLE;
        end else if (push11) begin
            seq_hit = (state_q != CAP_IDLE);
            state_d = CAP_GOT11;
            c11_d   = c11;
        end else if (pushedge) begin
            if (state_q == CAP_GOT11) begin
                state_d = CAP_GOTEDGE;
                c12_d   = c12;
                c21_d   = c21;
            end else begin
                seq_hit = 1'b1;
                state_d = CAP_IDLE;
            end
        end else if (push22) begin
            state_d = CAP_IDLE;
            if (state_q == CAP_GOTEDGE) commit  = 1'b1;
            else                        seq_hit = 1'b1;
        end
    end

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign last_tag = (total_q != '0) && (cnt_inc == total_q);

    always_comb begin
        wr_entry      = '0;
        wr_entry.c11  = c11_q;
        wr_entry.c12  = c12_q;
        wr_entry.c21  = c21_q;
        wr_entry.c22  = c22;
        wr_entry.last = last_tag;
    end

    // Serializer: walks the head tile element by element.
    assign head = entry_t'(rd_raw);

    always_comb begin
        elem = '0;
        case (idx_q)
            2'd0:    elem = head.c11;
            2'd1:    elem = head.c12;
            2'd2:    elem = head.c21;
            default: elem = head.c22;
        endcase
    end

    assign out.out_valid = !fifo_empty;
    assign out.out_data  = fifo_empty ? '0 : elem;
    assign out.out_last  = !fifo_empty && (idx_q == 2'd3) && head.last;

    // Handshakes in a start cycle are discarded along with the flushed queue.
    assign hs    = out.out_valid && out.out_ready && !start;
    assign pop   = hs && (idx_q == 2'd3);
    assign wr_en = commit && (!fifo_full || pop);

    always_comb begin
        cnt_d      = cnt_q;
        total_d    = total_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        seq_err_d  = seq_err_q;
        all_done_d = all_done_q;
        if (start) begin
            cnt_d      = '0;
            total_d    = tiles_total;
            idx_d      = '0;
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
            all_done_d = 1'b0;
        end else begin
            if (wr_en) cnt_d = cnt_inc;
            if (hs)    idx_d = idx_q + 2'd1;
            if (commit && fifo_full && !pop) overflow_d = 1'b1;
            if (seq_hit) seq_err_d = 1'b1;
            if (hs && out.out_last) all_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CAP_IDLE;
            c11_q      <= '0;
            c12_q      <= '0;
            c21_q      <= '0;
            cnt_q      <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            c11_q      <= c11_d;
            c12_q      <= c12_d;
            c21_q      <= c21_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
            all_done_q <= all_done_d;
        end
    end

    tile_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (start),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_raw),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign overflow = overflow_q;
    assign seq_err  = seq_err_q;
    assign all_done = all_done_q;

endmodule
